// File: rtl/dac_sched_pkg.sv
// Shared register map and bit positions for the DAC sample scheduler.
// Imported by the scheduler top and its FIFO.
package dac_sched_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DIV  = 2'd1;
  localparam logic [1:0] REG_FIFO = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam int STAT_EMPTY    = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_UNDERRUN = 2;
  localparam int STAT_COUNT    = 8;

  function automatic logic [3:0] reg_onehot(
    input logic [1:0] a
  );
    return 4'b0001 << a;
  endfunction

endpackage

// File: rtl/dac_sample_scheduler_if.sv
// APB slave bundle for the DAC sample scheduler.
// master drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB; slave returns PREADY/PRDATA/PSLVERR.
interface dac_sample_scheduler_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE,
    output PADDR, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE,
    input  PADDR, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO: push/pop/full/empty/count, head shown on rdata.
// Ports: CLK, RST, push, pop, wdata -> rdata, full, empty, count.
module dac_sample_fifo
  import dac_sched_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// APB-programmed DAC sample scheduler: releases one FIFO sample every DIV+1 cycles.
// Ports: CLK, RST, apb (slave), DATA, UPDATE pulse, IRQ (underrun & IE).
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  dac_sample_scheduler_if.slave  apb,
  output logic [DATA_W-1:0]      DATA,
  output logic                   UPDATE,
  output logic                   IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic              wr;
  logic [3:0]        sel;
  logic [31:0]       wmask;
  logic              en;
  logic              ie;
  logic              underrun;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  divcnt;
  logic              tick;
  logic              pop;
  logic              push_req;
  logic              strb_ok;
  logic              push;
  logic              clr;
  logic [DATA_W-1:0] head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [31:0]       stat;
  logic [31:0]       rmux;
  logic              unused;

  assign wr  = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign sel = reg_onehot(apb.PADDR[3:2]);

  assign wmask = {
    {8{apb.PSTRB[3]}}, {8{apb.PSTRB[2]}},
    {8{apb.PSTRB[1]}}, {8{apb.PSTRB[0]}}
  };

  assign tick = en & (divcnt == div);
  assign pop  = tick & ~empty;

  assign push_req = wr & sel[REG_FIFO];
  assign strb_ok  = &apb.PSTRB[1:0];
  assign push     = push_req & strb_ok & (~full | pop);
  assign clr      = wr & sel[REG_STAT] & apb.PWDATA[STAT_UNDERRUN];

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = push_req & (~strb_ok | (full & ~pop));
  assign apb.PRDATA  = rmux;

  assign unused = ^{apb.PADDR[31:4], apb.PADDR[1:0],
                    apb.PWDATA[31:DIV_W], wmask[31:DIV_W]};

  dac_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (apb.PWDATA[DATA_W-1:0]),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    stat = '0;
    stat[STAT_EMPTY]        = empty;
    stat[STAT_FULL]         = full;
    stat[STAT_UNDERRUN]     = underrun;
    stat[STAT_COUNT +: CW]  = count;
    rmux = '0;
    if (apb.PSEL & ~apb.PWRITE) begin
      unique case (1'b1)
        sel[REG_CTRL]: begin
          rmux[CTRL_EN] = en;
          rmux[CTRL_IE] = ie;
        end
        sel[REG_DIV]:  rmux[DIV_W-1:0] = div;
        sel[REG_FIFO]: rmux = '0;
        sel[REG_STAT]: rmux = stat;
        default:       rmux = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      div      <= '0;
      divcnt   <= '0;
      underrun <= 1'b0;
      DATA     <= '0;
      UPDATE   <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (wr & sel[REG_CTRL] & apb.PSTRB[0]) begin
        en <= apb.PWDATA[CTRL_EN];
        ie <= apb.PWDATA[CTRL_IE];
      end
      if (wr & sel[REG_DIV]) begin
        div <= (div & ~wmask[DIV_W-1:0])
             | (apb.PWDATA[DIV_W-1:0] & wmask[DIV_W-1:0]);
      end
      // Counter runs free past a lowered DIV and wraps naturally.
      if (!en)       divcnt <= '0;
      else if (tick) divcnt <= '0;
      else           divcnt <= divcnt + 1'b1;
      UPDATE <= pop;
      if (pop) DATA <= head;
      // Set beats a same-cycle write-1-clear.
      if (tick & empty) underrun <= 1'b1;
      else if (clr)     underrun <= 1'b0;
      IRQ <= underrun & ie;
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed testbench for dac_sample_scheduler.
// Scenario tasks run in sequence; summary line at the end.
module tb_dac_sample_scheduler;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_DIV  = 32'h4;
  localparam logic [31:0] A_FIFO = 32'h8;
  localparam logic [31:0] A_STAT = 32'hC;

  logic        clk;
  logic        rst;
  logic [11:0] data;
  logic        update;
  logic        irq;
  int          nvec;
  int          nerr;

  dac_sample_scheduler_if bus ();

  dac_sample_scheduler #(
    .DATA_W     (12),
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .apb    (bus),
    .DATA   (data),
    .UPDATE (update),
    .IRQ    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apb_write(
    input  logic [31:0] addr,
    input  logic [31:0] wdat,
    input  logic [3:0]  strb,
    output logic        err
  );
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = addr;
    bus.PWDATA  = wdat;
    bus.PSTRB   = strb;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1 err = bus.PSLVERR;
    @(negedge clk);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
  endtask

  task automatic apb_read(
    input  logic [31:0] addr,
    output logic [31:0] rdat
  );
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = addr;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    #1 rdat = bus.PRDATA;
    @(negedge clk);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic        e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (data !== 12'h0 || update !== 1'b0 || irq !== 1'b0) begin
      $display("FAIL reset_out: data=%h upd=%b irq=%b want 000/0/0", data, update, irq);
      nerr++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    nvec++;
    if (bus.PRDATA !== 32'h0 || bus.PREADY !== 1'b1 || bus.PSLVERR !== 1'b0) begin
      $display("FAIL idle_bus: prdata=%h pready=%b pslverr=%b want 0/1/0",
               bus.PRDATA, bus.PREADY, bus.PSLVERR);
      nerr++;
    end
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h1) begin
      $display("FAIL reset_stat: got %h want 00000001", r);
      nerr++;
    end
    apb_write(A_DIV, 32'h1, 4'hF, e);
    apb_write(A_FIFO, 32'h0AA, 4'hF, e);
    apb_write(A_FIFO, 32'h0BB, 4'hF, e);
    apb_write(A_FIFO, 32'h0CC, 4'hF, e);
    apb_write(A_CTRL, 32'h1, 4'hF, e);
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (data !== 12'h0AA) begin
      $display("FAIL stream_pre_reset: data=%h want 0aa", data);
      nerr++;
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      if (data !== 12'h0 || update !== 1'b0) begin
        $display("FAIL midreset_%0d: data=%h upd=%b want 000/0", i, data, update);
        nerr++;
      end
    end
    @(negedge clk);
    rst = 1'b0;
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h1) begin
      $display("FAIL midreset_stat: got %h want 00000001", r);
      nerr++;
    end
    apb_read(A_CTRL, r);
    nvec++;
    if (r !== 32'h0) begin
      $display("FAIL midreset_ctrl: got %h want 00000000", r);
      nerr++;
    end
    apb_read(A_DIV, r);
    nvec++;
    if (r !== 32'h0) begin
      $display("FAIL midreset_div: got %h want 00000000", r);
      nerr++;
    end
  endtask

  task automatic test_rate;
    logic        e;
    logic [11:0] exp_d;
    apb_write(A_DIV, 32'h4, 4'hF, e);
    apb_write(A_FIFO, 32'h123, 4'hF, e);
    apb_write(A_FIFO, 32'h456, 4'hF, e);
    apb_write(A_CTRL, 32'h3, 4'hF, e);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      exp_d = (k >= 10) ? 12'h456 : (k >= 5) ? 12'h123 : 12'h000;
      nvec++;
      if (update !== (k == 5 || k == 10) || data !== exp_d) begin
        $display("FAIL rate_k%0d: upd=%b data=%h want %b/%h",
                 k, update, data, (k == 5 || k == 10), exp_d);
        nerr++;
      end
    end
  endtask

  task automatic test_underrun;
    logic [31:0] r;
    logic        e;
    for (int k = 11; k <= 16; k++) begin
      @(posedge clk);
      #1;
      nvec++;
      if (update !== 1'b0 || data !== 12'h456 || irq !== (k >= 16)) begin
        $display("FAIL underrun_k%0d: upd=%b data=%h irq=%b want 0/456/%b",
                 k, update, data, irq, (k >= 16));
        nerr++;
      end
    end
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h5) begin
      $display("FAIL underrun_stat: got %h want 00000005", r);
      nerr++;
    end
    apb_write(A_CTRL, 32'h2, 4'hF, e);
    nvec++;
    if (irq !== 1'b1) begin
      $display("FAIL irq_held: got %b want 1", irq);
      nerr++;
    end
    apb_write(A_STAT, 32'h4, 4'hF, e);
    @(posedge clk);
    #1;
    nvec++;
    if (irq !== 1'b0) begin
      $display("FAIL irq_clear: got %b want 0", irq);
      nerr++;
    end
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h1) begin
      $display("FAIL underrun_cleared: got %h want 00000001", r);
      nerr++;
    end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    logic        e;
    for (int i = 1; i <= 9; i++) begin
      apb_write(A_FIFO, 32'(i), 4'hF, e);
      nvec++;
      if (e !== (i == 9)) begin
        $display("FAIL push_%0d_err: got %b want %b", i, e, (i == 9));
        nerr++;
      end
    end
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h0802) begin
      $display("FAIL full_stat: got %h want 00000802", r);
      nerr++;
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] r;
    logic        e;
    apb_write(A_DIV, 32'h0, 4'hF, e);
    // Enable access immediately followed by a push access, so the
    // first tick lands on a push while the FIFO is still full.
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = A_CTRL;
    bus.PWDATA  = 32'h1;
    bus.PSTRB   = 4'hF;
    @(negedge clk);
    bus.PENABLE = 1'b1;
    @(negedge clk);
    bus.PADDR   = A_FIFO;
    bus.PWDATA  = 32'h0ABC;
    #1;
    nvec++;
    if (bus.PSLVERR !== 1'b0) begin
      $display("FAIL simul_pslverr: got %b want 0", bus.PSLVERR);
      nerr++;
    end
    @(posedge clk);
    #1;
    nvec++;
    if (update !== 1'b1 || data !== 12'h001) begin
      $display("FAIL simul_pop: upd=%b data=%h want 1/001", update, data);
      nerr++;
    end
    @(negedge clk);
    bus.PWRITE = 1'b0;
    bus.PADDR  = A_STAT;
    #1;
    nvec++;
    if (bus.PRDATA !== 32'h0802) begin
      $display("FAIL simul_count: got %h want 00000802", bus.PRDATA);
      nerr++;
    end
    @(posedge clk);
    #1;
    nvec++;
    if (update !== 1'b1 || data !== 12'h002) begin
      $display("FAIL simul_pop2: upd=%b data=%h want 1/002", update, data);
      nerr++;
    end
    @(negedge clk);
    bus.PWRITE = 1'b1;
    bus.PADDR  = A_CTRL;
    bus.PWDATA = 32'h0;
    @(negedge clk);
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    @(posedge clk);
    #1;
    nvec++;
    if (update !== 1'b0 || data !== 12'h003) begin
      $display("FAIL simul_stop: upd=%b data=%h want 0/003", update, data);
      nerr++;
    end
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h0600) begin
      $display("FAIL simul_stat: got %h want 00000600", r);
      nerr++;
    end
  endtask

  task automatic test_strobes;
    logic [31:0] r;
    logic        e;
    apb_write(A_FIFO, 32'h777, 4'b0001, e);
    nvec++;
    if (e !== 1'b1) begin
      $display("FAIL strb_push_err: got %b want 1", e);
      nerr++;
    end
    apb_read(A_STAT, r);
    nvec++;
    if (r !== 32'h0600) begin
      $display("FAIL strb_push_count: got %h want 00000600", r);
      nerr++;
    end
    apb_write(A_DIV, 32'h1234, 4'hF, e);
    apb_write(A_DIV, 32'h0000_AB00, 4'b0010, e);
    apb_read(A_DIV, r);
    nvec++;
    if (r !== 32'hAB34) begin
      $display("FAIL strb_div: got %h want 0000ab34", r);
      nerr++;
    end
    apb_write(A_CTRL, 32'h3, 4'b0010, e);
    apb_read(A_CTRL, r);
    nvec++;
    if (r !== 32'h0 || e !== 1'b0) begin
      $display("FAIL strb_ctrl: got %h err=%b want 00000000/0", r, e);
      nerr++;
    end
    apb_read(A_FIFO, r);
    nvec++;
    if (r !== 32'h0) begin
      $display("FAIL fifo_read: got %h want 00000000", r);
      nerr++;
    end
  endtask

  initial begin
    nvec        = 0;
    nerr        = 0;
    rst         = 1'b1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
    bus.PSTRB   = '0;
    test_reset();
    test_rate();
    test_underrun();
    test_overflow();
    test_simultaneous();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
